// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
//   Multi-cycle WIDTH-bit adder that reuses a single 4-bit ripple-carry stage
//   (fulladder4bit). One operand pair is accepted per operation. The design
//   adds one nibble per clock, least-significant nibble first. The carry
//   between nibbles passes through a register.
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : a/b/c_in carry a valid operand pair
//   in_ready   : block is idle and can accept an operand pair
//   a, b       : WIDTH-bit operands
//   c_in       : carry into nibble 0
//   out_valid  : sum/c_out hold a completed result
//   out_ready  : consumer takes the result
//   sum        : registered WIDTH-bit sum
//   c_out      : registered carry out of the top nibble
// -----------------------------------------------------------------------------

// 4-bit ripple-carry adder stage: {c_out, sum} = a + b + c_in.
module fulladder4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);

  logic [4:0] carry;

  always_comb begin
    // NOTE: combinational logic uses blocking '=' so each bit sees the carry
    // produced by the previous iteration in the same evaluation. Every output
    // gets a default first, so no path can leave a latch behind.
    carry    = '0;
    sum      = '0;
    carry[0] = c_in;
    for (int i = 0; i < 4; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    c_out = carry[4];
  end

endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int NIBBLES = WIDTH / 4;
  // The index is kept at least one bit wide, so WIDTH=4 still has a legal register.
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;

  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       nib_sum;
  logic             nib_cout;

  // The shared adder stage always sees the current nibble of the latched operands.
  assign nib_a = a_q[4*idx +: 4];
  assign nib_b = b_q[4*idx +: 4];

  fulladder4bit u_stage (
    .a     (nib_a),
    .b     (nib_b),
    .c_in  (carry_q),
    .sum   (nib_sum),
    .c_out (nib_cout)
  );

  // The handshake outputs come straight from the registered state.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum     <= '0;
      c_out   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking '<=' so every register samples
      // values from before the edge, independent of statement order.
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= c_in;
            idx     <= '0;
            sum     <= '0;
            state   <= RUN;
          end
        end

        RUN: begin
          sum[4*idx +: 4] <= nib_sum;
          carry_q         <= nib_cout;
          if (idx == LAST_IDX) begin
            c_out <= nib_cout;
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        DONE: begin
          // The result stays held until the consumer takes it. The next accept
          // is possible only from IDLE, on a later edge.
          if (out_ready) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_adder
//   Directed bench for nibble_serial_adder. One 16-bit instance and one 4-bit
//   instance share the clock and reset. Expected values are hand-computed
//   constants. For the 4-bit instance they come from plain integer addition.
// -----------------------------------------------------------------------------
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 16-bit instance
  logic        in_valid16, in_ready16, out_valid16, out_ready16, c_in16, c_out16;
  logic [15:0] a16, b16, sum16;

  // 4-bit instance
  logic        in_valid4, in_ready4, out_valid4, out_ready4, c_in4, c_out4;
  logic [3:0]  a4, b4, sum4;

  int checks   = 0;
  int failures = 0;

  nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .a         (a16),
    .b         (b16),
    .c_in      (c_in16),
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .sum       (sum16),
    .c_out     (c_out16)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .a         (a4),
    .b         (b4),
    .c_in      (c_in4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .sum       (sum4),
    .c_out     (c_out4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset16(input string tag);
    check({tag, "_in_ready"},  in_ready16,  1);
    check({tag, "_out_valid"}, out_valid16, 0);
    check({tag, "_sum"},       sum16,       0);
    check({tag, "_c_out"},     c_out16,     0);
  endtask

  // Waits (bounded) for in_ready, then presents one operand pair for exactly one edge.
  task automatic start16(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic cin);
    int n = 0;
    @(negedge clk);
    while (!in_ready16 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_in_ready"}, in_ready16, 1);
    a16 = a; b16 = b; c_in16 = cin; in_valid16 = 1'b1;
    @(posedge clk);
    #1 in_valid16 = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid is seen. A timeout returns 20.
  task automatic wait_done16(output int cnt);
    cnt = 0;
    while (cnt < 20) begin
      @(posedge clk);
      #1 cnt++;
      if (out_valid16) break;
    end
  endtask

  task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic [15:0] exp_sum, input logic exp_cout);
    int cnt;
    out_ready16 = 1'b1;
    start16(tag, a, b, cin);
    wait_done16(cnt);
    check({tag, "_latency"}, cnt, 4);
    check({tag, "_sum"},     sum16, exp_sum);
    check({tag, "_c_out"},   c_out16, exp_cout);
    @(posedge clk);
    #1 check({tag, "_valid_drop"}, out_valid16, 0);
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic cin);
    int cnt = 0;
    int n   = 0;
    logic [4:0] exp;
    exp = 5'(int'(a) + int'(b) + int'(cin));
    @(negedge clk);
    while (!in_ready4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    a4 = a; b4 = b; c_in4 = cin; in_valid4 = 1'b1;
    @(posedge clk);
    #1 in_valid4 = 1'b0;
    while (cnt < 20) begin
      @(posedge clk);
      #1 cnt++;
      if (out_valid4) break;
    end
    check($sformatf("w4_lat_%0h_%0h_%0d", a, b, cin), cnt, 1);
    check($sformatf("w4_sum_%0h_%0h_%0d", a, b, cin), {c_out4, sum4}, exp);
  endtask

  initial begin
    int cnt;
    logic seen;

    rst_n = 1'b1;
    in_valid16 = 1'b0; out_ready16 = 1'b1; a16 = '0; b16 = '0; c_in16 = 1'b0;
    in_valid4  = 1'b0; out_ready4  = 1'b1; a4  = '0; b4  = '0; c_in4  = 1'b0;

    // Power-up reset. The values are checked before the first clock edge.
    #2 rst_n = 1'b0;
    #1 check_reset16("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic additions and full-width carry ripple.
    run16("basic",  16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    run16("ripple", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
    run16("allone", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
    run16("topcy",  16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
    run16("midcy",  16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0);

    // Backpressure: DONE holds, and new operands offered meanwhile are ignored.
    out_ready16 = 1'b0;
    start16("bp", 16'hFFFF, 16'hFFFF, 1'b1);
    wait_done16(cnt);
    check("bp_latency", cnt, 4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp_valid_%0d", i), out_valid16, 1);
      check($sformatf("bp_ready_%0d", i), in_ready16, 0);
      check($sformatf("bp_sum_%0d", i),   sum16, 16'hFFFF);
      check($sformatf("bp_cout_%0d", i),  c_out16, 1);
      a16 = 16'h0001; b16 = 16'h0001; c_in16 = 1'b0; in_valid16 = 1'b1;
    end
    @(negedge clk);
    in_valid16  = 1'b0;
    out_ready16 = 1'b1;
    @(posedge clk);
    #1 check("bp_release_ready", in_ready16, 1);
    check("bp_release_valid", out_valid16, 0);
    check("bp_release_sum",   sum16, 16'hFFFF);
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1 seen = seen | out_valid16;
    end
    check("bp_no_phantom", seen, 0);

    // A reset in the middle of the clock during DONE clears the outputs with no edge.
    out_ready16 = 1'b0;
    start16("rdone", 16'hABCD, 16'h1111, 1'b0);
    wait_done16(cnt);
    check("rdone_sum", sum16, 16'hBCDE);
    #2 rst_n = 1'b0;
    #1 check_reset16("rdone");
    @(negedge clk);
    rst_n = 1'b1;
    out_ready16 = 1'b1;

    // A reset in the middle of RUN, after two nibbles, aborts the operation with no out_valid.
    start16("rrun", 16'hFFFF, 16'h0001, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset16("rrun");
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen = seen | out_valid16;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      seen = seen | out_valid16;
    end
    check("rrun_no_valid", seen, 0);
    run16("after_rst", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);

    // Exhaustive WIDTH=4 test: {c_out,sum} must equal a+b+c_in with a latency of one edge.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          run4(4'(ia), 4'(ib), 1'(ic));
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
